pll_clken_seq: RTL and testbench
================================

# pll_clken_seq

Parametrised clock-enable sequencer that sits directly behind the PLL wrapper. It turns the PLL `lock` output and per-channel enable requests into glitch-free, divided clock-enable strobes for downstream logic in the `clkin` domain. Unlike the fixed PLL output enables, it adds lock qualification, staggered channel release, runtime-programmable divide ratios and loss-of-lock shutdown.

## Interface
Parameters:
- CHANNELS, 5, number of enable channels (1..8)
- DIV_W, 8, width of each divide ratio
- LOCK_WAIT, 1024, cycles `lock` must stay high before release (≥1)
- STAGGER, 16, cycles between successive channel releases (≥1)

Ports:
- clkin  in  1  single clock; everything is synchronous to its rising edge
- reset  in  1  asynchronous, active-high reset
- lock  in  1  PLL lock, already synchronised to `clkin`
- div_i  in  CHANNELS*DIV_W  divide ratio for channel k at bits [k*DIV_W +: DIV_W]
- load_i  in  1  one-cycle pulse that captures all of `div_i` into shadow registers
- enclk_i  in  CHANNELS  per-channel enable request (level)
- ce_o  out  CHANNELS  per-channel one-cycle clock-enable strobe
- ready_o  out  1  high while the FSM is in RUN
- lost_o  out  1  sticky flag, set on loss of lock while in RELEASE or RUN

## Operation
- Reset values:
  - `ce_o`=0, `ready_o`=0, `lost_o`=0.
  - FSM=WAIT_LOCK, all counters=0, all channels inactive.
  - Every shadow divider=1.
- FSM:
  - WAIT_LOCK: go to SETTLE when `lock`=1.
  - SETTLE: the settle counter increments while `lock`=1. If `lock` drops, return to WAIT_LOCK and clear the counter. When the count reaches LOCK_WAIT-1, go to RELEASE.
  - RELEASE: the release counter r increments each cycle. Channel k becomes *permitted* at r = k*STAGGER. After channel CHANNELS-1 is permitted, go to RUN.
  - RUN: hold while `lock`=1.
- Loss of lock: `lock`=0 in RELEASE or RUN has the following effects:
  - go to WAIT_LOCK, set `lost_o`;
  - force all channels inactive and clear all counters;
  - `ce_o` is 0 from the next cycle.
  - `lost_o` clears only on reset.
- Channel activity: a channel is *active* when it is permitted AND `enclk_i[k]`=1. The active flag may change only when the channel is inactive or at its terminal count, so no short strobe is ever produced. A deassert mid-period completes the current period and its final strobe.
- Per-channel counter: counts 0..D-1, where D is the shadow divider.
  - `ce_o[k]`=1 for exactly the cycle in which the counter equals D-1.
  - A shadow value of 0 is treated as D=1, which gives `ce_o` high every cycle.
  - An inactive channel holds its counter at 0 and drives `ce_o[k]`=0.
- Divider update: `load_i` copies `div_i` into a pending register and sets a per-channel pending flag.
  - Pending values move to the shadow register at the channel's next terminal count, or immediately if the channel is inactive.
  - A second `load_i` before that point overwrites the pending value (last wins).
- Counter width is DIV_W. No arithmetic overflow is possible because the count stops at D-1 ≤ 2^DIV_W-2.

## Timing
- Outputs are registered, giving one cycle of latency from the state or counter condition to the output.
- Strobe timing: if channel k becomes active at the edge where its counter is 0, the first strobe appears D cycles later. Strobes then repeat every D cycles.
- Release timing:
  - `ready_o` rises at cycle LOCK_WAIT + (CHANNELS-1)*STAGGER + 2 after `lock` first rises, with `lock` held high.
  - Channel k is permitted LOCK_WAIT + k*STAGGER + 1 cycles after `lock` rises.
- Simultaneous events:
  - `load_i` at a terminal count: the new value applies from the following period.
  - `lock` drop in the same cycle as a terminal count: no strobe is emitted.
  - `reset` mid-operation clears everything asynchronously.

## Structure
- Package `pll_clken_pkg` holds:
  - FSM state enum {WAIT_LOCK, SETTLE, RELEASE, RUN};
  - a `clog2`-based width helper for the settle and release counters.
- Sub-module `pll_clken_chan` contains one channel: counter, shadow/pending divider and active flag. It is instantiated CHANNELS times with a generate loop. The top level holds the FSM, the counters and the permit vector.

## Test plan
- Settle abort: CHANNELS=2, LOCK_WAIT=8, STAGGER=4. Pulse `lock` high 5 cycles, then low → FSM returns to WAIT_LOCK and `ready_o` stays 0. Hold `lock` high → `ready_o` rises 14 cycles after `lock` rises.
- Division: `div_i`={3,1}, all enables on → after release, `ce_o[0]` fires every cycle and `ce_o[1]` fires every 3rd cycle, with no other strobes.
- Reload at terminal count: ratio 4, `load_i` with 2 on the terminal-count cycle → one more strobe exactly 4 cycles later, then strobes every 2 cycles.
- Zero divide and mid-period disable: ratio 0 → `ce_o` high every cycle. Ratio 5, `enclk_i` dropped 2 cycles into a period → one final strobe 3 cycles later, then silence.
- Lock loss in RUN: drop `lock` → `ce_o` all 0 the next cycle, `ready_o`=0, `lost_o`=1 held until reset, and the full sequence restarts when `lock` returns.
- Async reset during RELEASE → all outputs 0 immediately without waiting for a `clkin` edge, and shadow dividers read back as 1.

Source files
------------

// File: rtl/pll_clken_pkg.sv
// rtl/pll_clken_pkg.sv - shared types and width helper for the PLL clock-enable sequencer
package pll_clken_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RELEASE,
        RUN
    } state_e;

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_clken_chan.sv
// rtl/pll_clken_chan.sv - one enable channel: divide counter, pending/shadow divider, active flag
module pll_clken_chan #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             permit_i,
    input  logic             enclk_i,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             ce_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0] pend_val_q, pend_val_d;
    logic [DIV_W-1:0] d_last;
    logic             pend_q, pend_d;
    logic             active_q, active_d;
    logic             ce_q, ce_d;
    logic             term;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            shadow_q   <= DIV_W'(1);
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            active_q   <= 1'b0;
            ce_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            active_q   <= active_d;
            ce_q       <= ce_d;
        end
    end

    always_comb begin
        // A zero divider behaves as divide-by-one.
        d_last     = (shadow_q == '0) ? '0 : shadow_q - 1'b1;
        term       = active_q && (cnt_q == d_last);
        cnt_d      = cnt_q;
        active_d   = active_q;
        ce_d       = 1'b0;
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;

        if (flush_i) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else begin
            ce_d  = term;
            cnt_d = (!active_q || term) ? '0 : cnt_q + 1'b1;
            if (!active_q || term) begin
                active_d = permit_i && enclk_i;
            end
        end

        // Divider changes only at a period boundary, so a period is never cut short.
        if (pend_q && (!active_q || term)) begin
            shadow_d = pend_val_q;
            pend_d   = 1'b0;
        end
        if (load_i) begin
            pend_val_d = div_i;
            pend_d     = 1'b1;
        end
    end

    assign ce_o = ce_q;

endmodule

// File: rtl/pll_clken_seq.sv
// rtl/pll_clken_seq.sv - lock-qualified, staggered release of divided clock-enable strobes
module pll_clken_seq
    import pll_clken_pkg::*;
#(
    parameter int CHANNELS  = 5,
    parameter int DIV_W     = 8,
    parameter int LOCK_WAIT = 1024,
    parameter int STAGGER   = 16
) (
    input  logic                      clkin,
    input  logic                      reset,
    input  logic                      lock,
    input  logic [CHANNELS*DIV_W-1:0] div_i,
    input  logic                      load_i,
    input  logic [CHANNELS-1:0]       enclk_i,
    output logic [CHANNELS-1:0]       ce_o,
    output logic                      ready_o,
    output logic                      lost_o
);

    localparam int SET_W = cnt_w(LOCK_WAIT);
    localparam int REL_W = cnt_w((CHANNELS - 1) * STAGGER + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_WAIT - 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'((CHANNELS - 1) * STAGGER);

    state_e              state_q, state_d;
    logic [SET_W-1:0]    set_q, set_d;
    logic [REL_W-1:0]    rel_q, rel_d;
    logic                lost_q, lost_d;
    logic                flush;
    logic [CHANNELS-1:0] permit;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
            set_q   <= '0;
            rel_q   <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            rel_q   <= rel_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        rel_d   = rel_q;
        lost_d  = lost_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock) state_d = SETTLE;
            end
            SETTLE: begin
                if (!lock) begin
                    state_d = WAIT_LOCK;
                    set_d   = '0;
                end else if (set_q == SET_LAST) begin
                    state_d = RELEASE;
                    set_d   = '0;
                end else begin
                    set_d = set_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!lock) begin
                    state_d = WAIT_LOCK;
                    rel_d   = '0;
                    lost_d  = 1'b1;
                end else if (rel_q == REL_LAST) begin
                    state_d = RUN;
                    rel_d   = '0;
                end else begin
                    rel_d = rel_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock) begin
                    state_d = WAIT_LOCK;
                    lost_d  = 1'b1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    always_comb begin
        flush   = !lock && ((state_q == RELEASE) || (state_q == RUN));
        ready_o = (state_q == RUN);
        lost_o  = lost_q;
        permit  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            permit[k] = (state_q == RUN) ||
                        ((state_q == RELEASE) && (rel_q >= REL_W'(k * STAGGER)));
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        pll_clken_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .clk_i   (clkin),
            .rst_i   (reset),
            .permit_i(permit[k]),
            .enclk_i (enclk_i[k]),
            .flush_i (flush),
            .load_i  (load_i),
            .div_i   (div_i[k*DIV_W +: DIV_W]),
            .ce_o    (ce_o[k])
        );
    end

endmodule

// File: tb/tb_pll_clken_seq.sv
// tb/tb_pll_clken_seq.sv - directed self-checking bench for pll_clken_seq
module tb_pll_clken_seq;

    logic        clkin;
    logic        reset;
    logic        lock;
    logic [15:0] div_i;
    logic        load_i;
    logic [1:0]  enclk_i;
    logic [1:0]  ce_o;
    logic        ready_o;
    logic        lost_o;

    int n_checks = 0;
    int n_errors = 0;

    pll_clken_seq #(
        .CHANNELS (2),
        .DIV_W    (8),
        .LOCK_WAIT(8),
        .STAGGER  (4)
    ) dut (
        .clkin  (clkin),
        .reset  (reset),
        .lock   (lock),
        .div_i  (div_i),
        .load_i (load_i),
        .enclk_i(enclk_i),
        .ce_o   (ce_o),
        .ready_o(ready_o),
        .lost_o (lost_o)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        @(negedge clkin);
    endtask

    task automatic load_div(input logic [7:0] d1, input logic [7:0] d0);
        div_i  = {d1, d0};
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
    endtask

    // Park channel 1 idle, give it a new ratio and leave it ready to enable.
    task automatic arm_ch1(input logic [7:0] d1);
        enclk_i[1] = 1'b0;
        repeat (12) tick();
        load_div(d1, 8'd1);
        tick();
    endtask

    initial begin
        logic exp1;
        reset   = 1'b1;
        lock    = 1'b0;
        div_i   = '0;
        load_i  = 1'b0;
        enclk_i = '0;

        #2;
        check("rst_ce", ce_o, 0);
        check("rst_ready", ready_o, 0);
        check("rst_lost", lost_o, 0);
        tick();
        tick();
        reset = 1'b0;

        load_div(8'd3, 8'd1);
        enclk_i = 2'b11;
        tick();

        // Settle abort
        lock = 1'b1;
        repeat (5) tick();
        lock = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            tick();
            check("abort_ready", ready_o, 0);
            check("abort_ce", ce_o, 0);
        end

        // Full release with ch0 ratio 1, ch1 ratio 3
        lock = 1'b1;
        for (int n = 1; n <= 26; n++) begin
            tick();
            exp1 = (n >= 17) && (((n - 17) % 3) == 0);
            check("rel_ready", ready_o, (n >= 14) ? 1 : 0);
            check("rel_ce", ce_o, {exp1, (n >= 11) ? 1'b1 : 1'b0});
        end
        check("rel_lost", lost_o, 0);

        // Reload at terminal count: ratio 4 then 2
        arm_ch1(8'd4);
        enclk_i[1] = 1'b1;
        for (int m = 1; m <= 16; m++) begin
            tick();
            exp1 = (m == 5) || (m == 9) || (m == 11) || (m == 13) || (m == 15);
            check("reload_ce", ce_o, {exp1, 1'b1});
            if (m == 4) begin
                div_i  = {8'd2, 8'd1};
                load_i = 1'b1;
            end else begin
                load_i = 1'b0;
            end
        end

        // Zero divide behaves as divide-by-one
        arm_ch1(8'd0);
        enclk_i[1] = 1'b1;
        for (int m = 1; m <= 6; m++) begin
            tick();
            check("zero_ce", ce_o, {(m >= 2) ? 1'b1 : 1'b0, 1'b1});
        end

        // Mid-period disable with ratio 5
        arm_ch1(8'd5);
        enclk_i[1] = 1'b1;
        for (int m = 1; m <= 14; m++) begin
            tick();
            check("middis_ce", ce_o, {(m == 6) ? 1'b1 : 1'b0, 1'b1});
            if (m == 3) enclk_i[1] = 1'b0;
        end

        // Lock loss in RUN
        enclk_i = 2'b11;
        repeat (4) tick();
        check("run_ready", ready_o, 1);
        lock = 1'b0;
        tick();
        check("loss_ce", ce_o, 0);
        check("loss_ready", ready_o, 0);
        check("loss_lost", lost_o, 1);
        repeat (5) tick();
        check("loss_ce_hold", ce_o, 0);
        check("loss_lost_hold", lost_o, 1);
        lock = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            check("relock_ready", ready_o, (n >= 14) ? 1 : 0);
            if (n == 12) check("relock_ce0", ce_o[0], 1);
        end
        check("relock_lost", lost_o, 1);

        // Async reset during RELEASE
        lock = 1'b0;
        tick();
        lock = 1'b1;
        repeat (11) tick();
        check("pre_rst_ce", ce_o, 2'b01);
        check("pre_rst_ready", ready_o, 0);
        #2 reset = 1'b1;
        #1;
        check("arst_ce", ce_o, 0);
        check("arst_ready", ready_o, 0);
        check("arst_lost", lost_o, 0);
        @(negedge clkin);
        tick();
        reset = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            tick();
            check("post_rst_ready", ready_o, (n >= 14) ? 1 : 0);
            if (n >= 15) check("post_rst_div1", ce_o, 2'b11);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
